// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the pipeline-controller state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic {
    PC_RUN     = 1'b0,
    PC_BR_WAIT = 1'b1
  } pipe_ctrl_state_t;

endpackage : lc3b_types

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags a DE instruction that reads the
// destination of a load still sitting in EX.
module hazard_detect
  import lc3b_types::*;
(
  input  logic    de_valid,
  input  logic    de_uses_sr1,
  input  logic    de_uses_sr2,
  input  lc3b_reg de_sr1_idx,
  input  lc3b_reg de_sr2_idx,
  input  logic    ex_valid,
  input  logic    ex_is_load,
  input  lc3b_reg ex_dest,
  output logic    luse
);

  logic sr1_hit;
  logic sr2_hit;

  assign sr1_hit = de_uses_sr1 && (de_sr1_idx == ex_dest);
  assign sr2_hit = de_uses_sr2 && (de_sr2_idx == ex_dest);
  assign luse    = de_valid && ex_valid && ex_is_load && (sr1_hit || sr2_hit);

endmodule : hazard_detect

// File: rtl/pipe_ctrl.sv
// LC-3b five-stage pipeline hazard/stall controller. Optional perf counters
// (stall_cycles, flush_count) are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     imem_resp,
  input  logic     dmem_req,
  input  logic     dmem_resp,
  input  logic     de_valid,
  input  logic     de_uses_sr1,
  input  logic     de_uses_sr2,
  input  lc3b_reg  de_sr1_idx,
  input  lc3b_reg  de_sr2_idx,
  input  logic     ex_valid,
  input  logic     ex_is_load,
  input  lc3b_reg  ex_dest,
  input  logic     br_taken,
  input  lc3b_word br_target,
  output logic     load_fd,
  output logic     load_de,
  output logic     load_em,
  output logic     load_mw,
  output logic     fd_valid_in,
  output logic     de_valid_in,
  output logic     em_valid_in,
  output logic     pc_load,
  output logic     pc_redirect,
  output lc3b_word pc_target
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  pipe_ctrl_state_t state_q, state_d;
  lc3b_word         tgt_q, tgt_d;
  logic             luse;
  logic             mem_stall;

  assign mem_stall = dmem_req && !dmem_resp;

  hazard_detect u_hazard_detect (
    .de_valid    (de_valid),
    .de_uses_sr1 (de_uses_sr1),
    .de_uses_sr2 (de_uses_sr2),
    .de_sr1_idx  (de_sr1_idx),
    .de_sr2_idx  (de_sr2_idx),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_dest     (ex_dest),
    .luse        (luse)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PC_RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // NOTE: every output is given a default before the case so no path through
  // the block leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    load_fd     = 1'b1;
    load_de     = 1'b1;
    load_em     = 1'b1;
    load_mw     = 1'b1;
    fd_valid_in = 1'b1;
    de_valid_in = 1'b1;
    em_valid_in = 1'b1;
    pc_load     = 1'b1;
    pc_redirect = 1'b0;
    pc_target   = (state_q == PC_BR_WAIT) ? tgt_q : br_target;

    unique case (state_q)
      PC_RUN: begin
        if (mem_stall) begin
          load_fd = 1'b0;
          load_de = 1'b0;
          load_em = 1'b0;
          load_mw = 1'b0;
          pc_load = 1'b0;
        end else if (br_taken) begin
          de_valid_in = 1'b0;
          em_valid_in = 1'b0;
          if (imem_resp) begin
            fd_valid_in = 1'b0;
            pc_redirect = 1'b1;
          end else begin
            // Fetch still in flight: remember the target and squash it later.
            load_fd = 1'b0;
            pc_load = 1'b0;
            tgt_d   = br_target;
            state_d = PC_BR_WAIT;
          end
        end else if (!imem_resp || luse) begin
          load_fd     = 1'b0;
          pc_load     = 1'b0;
          de_valid_in = 1'b0;
        end
      end

      PC_BR_WAIT: begin
        de_valid_in = 1'b0;
        em_valid_in = 1'b0;
        if (!imem_resp) begin
          load_fd = 1'b0;
          pc_load = 1'b0;
        end else begin
          fd_valid_in = 1'b0;
          pc_redirect = 1'b1;
          state_d     = PC_RUN;
        end
      end

      default: state_d = PC_RUN;
    endcase

    if (!reset_n) begin
      load_fd     = 1'b0;
      load_de     = 1'b0;
      load_em     = 1'b0;
      load_mw     = 1'b0;
      fd_valid_in = 1'b0;
      de_valid_in = 1'b0;
      em_valid_in = 1'b0;
      pc_load     = 1'b0;
      pc_redirect = 1'b0;
      pc_target   = '0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!load_fd && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
      if (pc_redirect && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven RUN-state vectors plus
// hand-written branch-wait, stall and reset sequences, checked via scoreboard.
module tb_pipe_ctrl;

  typedef struct packed {
    logic        imem;
    logic        dreq;
    logic        dresp;
    logic        dev;
    logic        u1;
    logic        u2;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic        exv;
    logic        exl;
    logic [2:0]  exd;
    logic        br;
    logic [15:0] tgt;
  } in_t;

  // ctl = {load_fd,load_de,load_em,load_mw,fd_v,de_v,em_v,pc_load,pc_redirect}
  typedef struct packed {
    logic [8:0]  ctl;
    logic [15:0] tgt;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  exp;
  } vec_t;

  localparam logic [8:0] ADV    = 9'b1111_111_1_0;
  localparam logic [8:0] STALL  = 9'b0000_111_0_0;
  localparam logic [8:0] BUB    = 9'b0111_101_0_0;
  localparam logic [8:0] BRHIT  = 9'b1111_000_1_1;
  localparam logic [8:0] BRHOLD = 9'b0111_100_0_0;
  localparam logic [8:0] RSTOUT = 9'b0000_000_0_0;

  logic        clk;
  logic        reset_n;
  in_t         cur;
  logic        load_fd, load_de, load_em, load_mw;
  logic        fd_valid_in, de_valid_in, em_valid_in;
  logic        pc_load, pc_redirect;
  logic [15:0] pc_target;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tbl[15];

  pipe_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_resp   (cur.imem),
    .dmem_req    (cur.dreq),
    .dmem_resp   (cur.dresp),
    .de_valid    (cur.dev),
    .de_uses_sr1 (cur.u1),
    .de_uses_sr2 (cur.u2),
    .de_sr1_idx  (cur.s1),
    .de_sr2_idx  (cur.s2),
    .ex_valid    (cur.exv),
    .ex_is_load  (cur.exl),
    .ex_dest     (cur.exd),
    .br_taken    (cur.br),
    .br_target   (cur.tgt),
    .load_fd     (load_fd),
    .load_de     (load_de),
    .load_em     (load_em),
    .load_mw     (load_mw),
    .fd_valid_in (fd_valid_in),
    .de_valid_in (de_valid_in),
    .em_valid_in (em_valid_in),
    .pc_load     (pc_load),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(logic imem, logic dreq, logic dresp, logic dev,
                             logic u1, logic u2, logic [2:0] s1, logic [2:0] s2,
                             logic exv, logic exl, logic [2:0] exd, logic br,
                             logic [15:0] tgt);
    mk = '{imem: imem, dreq: dreq, dresp: dresp, dev: dev, u1: u1, u2: u2,
           s1: s1, s2: s2, exv: exv, exl: exl, exd: exd, br: br, tgt: tgt};
  endfunction

  function automatic exp_t ex(logic [8:0] ctl, logic [15:0] tgt);
    ex = '{ctl: ctl, tgt: tgt};
  endfunction

  task automatic check(input string name);
    exp_t e;
    logic [8:0] act;
    act = {load_fd, load_de, load_em, load_mw, fd_valid_in, de_valid_in,
           em_valid_in, pc_load, pc_redirect};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got ctl=%b tgt=%h", name, act, pc_target);
    end else begin
      e = sb.pop_front();
      if (act !== e.ctl || pc_target !== e.tgt) begin
        failures++;
        $display("FAIL %s: got ctl=%b tgt=%h, want ctl=%b tgt=%h",
                 name, act, pc_target, e.ctl, e.tgt);
      end
    end
  endtask

  // Drive one cycle's inputs shortly after the rising edge, sample mid-cycle.
  task automatic step(input string name, input in_t in, input exp_t e);
    cur = in;
    sb.push_back(e);
    #4;
    check(name);
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [15:0] act,
                           input logic [15:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  in_t free_run;

  initial begin
    free_run = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 3'd3, 1'b0, 16'h0100);

    tbl[0]  = '{"free_run",     free_run, ex(ADV, 16'h0100)};
    tbl[1]  = '{"luse_sr1",     mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,3'd3,3'd5,1'b1,1'b1,3'd3,1'b0,16'h0000), ex(BUB, 16'h0000)};
    tbl[2]  = '{"luse_sr2",     mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,3'd0,3'd6,1'b1,1'b1,3'd6,1'b0,16'h0002), ex(BUB, 16'h0002)};
    tbl[3]  = '{"no_uses",      mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,3'd3,3'd3,1'b1,1'b1,3'd3,1'b0,16'h0004), ex(ADV, 16'h0004)};
    tbl[4]  = '{"idx_differ",   mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,3'd2,3'd4,1'b1,1'b1,3'd3,1'b0,16'h0006), ex(ADV, 16'h0006)};
    tbl[5]  = '{"ex_invalid",   mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,3'd3,3'd0,1'b0,1'b1,3'd3,1'b0,16'h0008), ex(ADV, 16'h0008)};
    tbl[6]  = '{"de_invalid",   mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,3'd3,3'd0,1'b1,1'b1,3'd3,1'b0,16'h000A), ex(ADV, 16'h000A)};
    tbl[7]  = '{"ex_not_load",  mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,3'd3,3'd0,1'b1,1'b0,3'd3,1'b0,16'h000C), ex(ADV, 16'h000C)};
    tbl[8]  = '{"imem_miss",    mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,3'd1,1'b0,16'h000E), ex(BUB, 16'h000E)};
    tbl[9]  = '{"mem_stall",    mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,3'd1,1'b0,16'h0010), ex(STALL, 16'h0010)};
    tbl[10] = '{"stall_vs_br",  mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,3'd1,1'b1,16'h2222), ex(STALL, 16'h2222)};
    tbl[11] = '{"dmem_done",    mk(1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,3'd1,1'b0,16'h0012), ex(ADV, 16'h0012)};
    tbl[12] = '{"br_hit",       mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,3'd1,1'b1,16'h1234), ex(BRHIT, 16'h1234)};
    tbl[13] = '{"br_vs_luse",   mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,3'd4,3'd0,1'b1,1'b1,3'd4,1'b1,16'hBEEF), ex(BRHIT, 16'hBEEF)};
    tbl[14] = '{"stall_vs_luse",mk(1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,3'd4,3'd0,1'b1,1'b1,3'd4,1'b0,16'h0014), ex(STALL, 16'h0014)};

    reset_n = 1'b0;
    cur     = tbl[12].in;
    #1;
    step("reset_outputs", tbl[12].in, ex(RSTOUT, 16'h0000));
    reset_n = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
    check_val("perf_stall_reset", stall_cycles, 16'h0000);
    check_val("perf_flush_reset", flush_count, 16'h0000);
`endif

    foreach (tbl[i]) step(tbl[i].name, tbl[i].in, tbl[i].exp);

    // Load-use bubble then release once the bubble reaches EX.
    step("luse_bubble", tbl[1].in, ex(BUB, 16'h0000));
    step("luse_cleared", tbl[5].in, ex(ADV, 16'h0008));

    // Three-cycle dmem stall, advance on response.
    for (int i = 0; i < 3; i++) step($sformatf("dstall_%0d", i), tbl[9].in, ex(STALL, 16'h0010));
    step("dstall_resp", tbl[11].in, ex(ADV, 16'h0012));

    // Branch with fetch in flight: two wait cycles, then squash and redirect.
    step("brw_enter", mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,3'd1,1'b1,16'h0040), ex(BRHOLD, 16'h0040));
    step("brw_hold_ign", mk(1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,3'd2,3'd0,1'b1,1'b1,3'd2,1'b1,16'h9999), ex(BRHOLD, 16'h0040));
    step("brw_done", mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,3'd1,1'b0,16'h7777), ex(BRHIT, 16'h0040));
    step("brw_back_run", free_run, ex(ADV, 16'h0100));

    // Reset asserted while in BR_WAIT abandons the redirect.
    step("brw2_enter", mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,3'd1,1'b1,16'h0ABC), ex(BRHOLD, 16'h0ABC));
    reset_n = 1'b0;
    step("brw2_reset", mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,3'd1,1'b0,16'h0555), ex(RSTOUT, 16'h0000));
    reset_n = 1'b1;
    step("brw2_after_rst", mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,3'd1,1'b0,16'h0555), ex(ADV, 16'h0555));

`ifdef PIPE_CTRL_PERF_EN
    reset_n = 1'b0;
    #2;
    check_val("perf_stall_rst2", stall_cycles, 16'h0000);
    check_val("perf_flush_rst2", flush_count, 16'h0000);
    reset_n = 1'b1;
    step("perf_br", tbl[12].in, ex(BRHIT, 16'h1234));
    check_val("perf_flush_one", flush_count, 16'h0001);
    check_val("perf_stall_zero", stall_cycles, 16'h0000);
    cur = tbl[9].in;
    repeat (70000) @(posedge clk);
    #1;
    check_val("perf_stall_sat", stall_cycles, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_ctrl
